// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pipe
//  Purpose  : Parametrised valid/ready ALU with a registered 2*WIDTH result
//             and carry, zero and error flags. Unsigned divide is an
//             iterative restoring unit (one quotient bit per cycle). Every
//             other operation completes in a single cycle.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH   operand width in bits (>= 2). Result is 2*WIDTH wide.
//    CNT_W   width of the divide iteration counter (derived from WIDTH).
//  Ports
//    CLK        in   1        clock, rising edge
//    Reset      in   1        synchronous active-high reset
//    in_valid   in   1        operands and op_code are valid
//    in_ready   out  1        an operation can be accepted this cycle
//    A, B       in   WIDTH    unsigned operands
//    op_code    in   4        0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 XOR, 6 OR
//    C_in       in   1        carry-in (ADD only)
//    out_valid  out  1        Result and flags are valid
//    out_ready  in   1        downstream accepts the result
//    Result     out  2*WIDTH  result
//    C_out      out  1        carry (ADD) / borrow (SUB), 0 otherwise
//    Z_flag     out  1        Result == 0
//    Err        out  1        divide by zero or illegal op_code
//    V_flag     out  1        signed overflow of ADD/SUB (optional)
//  Build option
//    ALU_PIPE_OVF_FLAG_EN  when defined, adds the V_flag output.
// ============================================================================
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [3:0]           op_code,
    input  logic                 C_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   Result,
    output logic                 C_out,
    output logic                 Z_flag,
`ifdef ALU_PIPE_OVF_FLAG_EN
    output logic                 V_flag,
`endif
    output logic                 Err
);

    localparam int       c_W2     = 2 * WIDTH;
    localparam logic [3:0] c_OP_ADD = 4'd0;
    localparam logic [3:0] c_OP_SUB = 4'd1;
    localparam logic [3:0] c_OP_MUL = 4'd2;
    localparam logic [3:0] c_OP_DIV = 4'd3;
    localparam logic [3:0] c_OP_AND = 4'd4;
    localparam logic [3:0] c_OP_XOR = 4'd5;
    localparam logic [3:0] c_OP_OR  = 4'd6;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_DIVIDE = 1'b1
    } state_t;

    state_t              r_state;
    logic                r_out_valid;
    logic [c_W2-1:0]     r_result;
    logic                r_c;
    logic                r_z;
    logic                r_err;
    logic [CNT_W-1:0]    r_cnt;
    logic [WIDTH-1:0]    r_rem;
    logic [WIDTH-1:0]    r_quo;   // dividend shifts out the top, quotient in at the bottom
    logic [WIDTH-1:0]    r_dvs;

    logic                w_accept;
    logic [WIDTH:0]      w_sum;
    logic [WIDTH:0]      w_diff;
    logic [c_W2-1:0]     w_prod;
    logic [c_W2-1:0]     w_res;
    logic                w_c;
    logic                w_err;
    logic                w_start_div;

    logic [WIDTH:0]      w_rem_sh;
    logic [WIDTH:0]      w_trial;
    logic                w_ge;
    logic [WIDTH-1:0]    w_rem_nxt;
    logic [WIDTH-1:0]    w_quo_nxt;
    logic [c_W2-1:0]     w_div_res;
    logic                w_div_last;

`ifdef ALU_PIPE_OVF_FLAG_EN
    logic                r_v;
    logic                w_v;
`endif

    // Accept is only possible when idle and the output slot is free or
    // draining this same cycle.
    assign in_ready = (r_state == S_IDLE) && (!r_out_valid || out_ready) && !Reset;
    assign w_accept = in_valid && in_ready;

    assign w_sum  = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, C_in};
    assign w_diff = {1'b0, A} - {1'b0, B};   // MSB is the borrow (A < B)
    assign w_prod = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

    always_comb begin
        w_res       = '0;
        w_c         = 1'b0;
        w_err       = 1'b0;
        w_start_div = 1'b0;
        case (op_code)
            c_OP_ADD: begin
                w_res = {{(WIDTH-1){1'b0}}, w_sum};
                w_c   = w_sum[WIDTH];
            end
            c_OP_SUB: begin
                w_res = {{WIDTH{1'b0}}, w_diff[WIDTH-1:0]};
                w_c   = w_diff[WIDTH];
            end
            c_OP_MUL: w_res = w_prod;
            c_OP_DIV: begin
                if (B == '0) begin
                    // Divide by zero resolves immediately: all-ones quotient,
                    // dividend as remainder.
                    w_res = {A, {WIDTH{1'b1}}};
                    w_err = 1'b1;
                end else begin
                    w_start_div = 1'b1;
                end
            end
            c_OP_AND: w_res = {{WIDTH{1'b0}}, A & B};
            c_OP_XOR: w_res = {{WIDTH{1'b0}}, A ^ B};
            c_OP_OR:  w_res = {{WIDTH{1'b0}}, A | B};
            default:  w_err = 1'b1;
        endcase
    end

`ifdef ALU_PIPE_OVF_FLAG_EN
    always_comb begin
        w_v = 1'b0;
        if (op_code == c_OP_ADD)
            w_v = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
        else if (op_code == c_OP_SUB)
            w_v = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
    end
`endif

    // One restoring-division step: bring in the next dividend bit, try to
    // subtract the divisor, keep the difference only if it did not borrow.
    assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
    assign w_trial    = w_rem_sh - {1'b0, r_dvs};
    assign w_ge       = ~w_trial[WIDTH];
    assign w_rem_nxt  = w_ge ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_quo_nxt  = {r_quo[WIDTH-2:0], w_ge};
    assign w_div_res  = {w_rem_nxt, w_quo_nxt};
    assign w_div_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_c         <= 1'b0;
            r_z         <= 1'b1;
            r_err       <= 1'b0;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
`ifdef ALU_PIPE_OVF_FLAG_EN
            r_v         <= 1'b0;
`endif
        end else begin
            // Drain first; a load in the same cycle overrides it.
            if (r_out_valid && out_ready)
                r_out_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_start_div) begin
                            r_state <= S_DIVIDE;
                            r_rem   <= '0;
                            r_quo   <= A;
                            r_dvs   <= B;
                            r_cnt   <= '0;
                        end else begin
                            r_result    <= w_res;
                            r_c         <= w_c;
                            r_z         <= (w_res == '0);
                            r_err       <= w_err;
                            r_out_valid <= 1'b1;
`ifdef ALU_PIPE_OVF_FLAG_EN
                            r_v         <= w_v;
`endif
                        end
                    end
                end
                S_DIVIDE: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_div_last) begin
                        // The output slot is guaranteed empty here: it was
                        // free or draining when the divide was accepted.
                        r_state     <= S_IDLE;
                        r_result    <= w_div_res;
                        r_c         <= 1'b0;
                        r_z         <= (w_div_res == '0);
                        r_err       <= 1'b0;
                        r_out_valid <= 1'b1;
`ifdef ALU_PIPE_OVF_FLAG_EN
                        r_v         <= 1'b0;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign Result    = r_result;
    assign C_out     = r_c;
    assign Z_flag    = r_z;
    assign Err       = r_err;
`ifdef ALU_PIPE_OVF_FLAG_EN
    assign V_flag    = r_v;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_pipe
//  Purpose  : Self-checking bench for alu_pipe (WIDTH = 8). A reference model
//             computes every accepted operation with plain integer
//             arithmetic; a compare process checks each valid output cycle
//             against the head of the expectation queue. Directed checks pin
//             literal values, latency, throughput, backpressure and reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

    localparam int W = 8;

    logic            CLK = 1'b0;
    logic            Reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    A = '0;
    logic [W-1:0]    B = '0;
    logic [3:0]      op_code = '0;
    logic            C_in = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [2*W-1:0]  Result;
    logic            C_out;
    logic            Z_flag;
    logic            Err;
`ifdef ALU_PIPE_OVF_FLAG_EN
    logic            V_flag;
`endif

    alu_pipe #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .op_code   (op_code),
        .C_in      (C_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .C_out     (C_out),
        .Z_flag    (Z_flag),
`ifdef ALU_PIPE_OVF_FLAG_EN
        .V_flag    (V_flag),
`endif
        .Err       (Err)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [15:0] res;
        logic        c;
        logic        z;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        cin;
        logic [15:0] r;
    } vec_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    bit   bp_en    = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation's definition.
    function automatic exp_t model(input logic [3:0] op, input logic [7:0] a,
                                   input logic [7:0] b, input logic cin);
        int unsigned ua, ub, r;
        exp_t e;
        ua = a; ub = b; r = 0; e = '0;
        case (op)
            4'd0: begin r = ua + ub + cin;      e.c = (r > 255); end
            4'd1: begin r = (ua - ub) & 255;    e.c = (ua < ub); end
            4'd2: r = ua * ub;
            4'd3: begin
                if (ub == 0) begin r = ua * 256 + 255; e.err = 1'b1; end
                else         r = (ua % ub) * 256 + (ua / ub);
            end
            4'd4: r = ua & ub;
            4'd5: r = ua ^ ub;
            4'd6: r = ua | ub;
            default: e.err = 1'b1;
        endcase
        e.res = 16'(r);
        e.z   = (e.res == 16'h0000);
        return e;
    endfunction

    // Compare every valid output cycle against the oldest outstanding result.
    always @(negedge CLK) begin
        exp_t e;
        if (!Reset && out_valid) begin
            if (q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL stream: out_valid with no outstanding op, Result=%0h", Result);
            end else begin
                e = q[0];
                chk("stream.Result", Result, e.res);
                chk("stream.C_out",  C_out,  e.c);
                chk("stream.Z_flag", Z_flag, e.z);
                chk("stream.Err",    Err,    e.err);
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    // Random downstream backpressure, enabled for one phase only.
    always @(posedge CLK) begin
        if (bp_en) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Present an operation and hold it until accepted (bounded).
    // Called just after a rising edge; returns just after the accept edge.
    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, output int waits);
        op_code  = op; A = a; B = b; C_in = cin;
        in_valid = 1'b1;
        waits    = 0;
        @(negedge CLK); #1;
        while (!in_ready && waits < 60) begin
            waits++;
            @(negedge CLK); #1;
        end
        if (!in_ready) begin
            n_checks++;
            n_err++;
            $display("FAIL send: op %0d never accepted, in_ready=%0b", op, in_ready);
        end else begin
            q.push_back(model(op, a, b, cin));
        end
        @(posedge CLK); #1;
        in_valid = 1'b0;
        A = ~a; B = ~b;   // operands must only matter at the accept edge
    endtask

    vec_t tbl [12];

    initial begin
        int w;
        int lat;
        bit busy_bad;

        tbl = '{
            '{4'd0,  8'h7F, 8'h01, 1'b0, 16'h0080},
            '{4'd1,  8'h00, 8'h01, 1'b0, 16'h00FF},
            '{4'd4,  8'hF0, 8'h3C, 1'b0, 16'h0030},
            '{4'd5,  8'hAA, 8'h55, 1'b0, 16'h00FF},
            '{4'd6,  8'h00, 8'h00, 1'b0, 16'h0000},
            '{4'd2,  8'h10, 8'h10, 1'b0, 16'h0100},
            '{4'd0,  8'h80, 8'h80, 1'b0, 16'h0100},
            '{4'd15, 8'h01, 8'h02, 1'b1, 16'h0000},
            '{4'd3,  8'hFF, 8'h10, 1'b0, 16'h0F0F},
            '{4'd0,  8'h00, 8'h00, 1'b1, 16'h0001},
            '{4'd3,  8'h05, 8'h09, 1'b0, 16'h0500},
            '{4'd2,  8'h0C, 8'h0D, 1'b0, 16'h009C}
        };

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst.in_ready",  in_ready,  1'b0);
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.Result",    Result,    16'h0000);
        chk("rst.Z_flag",    Z_flag,    1'b1);
        chk("rst.C_out",     C_out,     1'b0);
        chk("rst.Err",       Err,       1'b0);
        Reset = 1'b0;
        out_ready = 1'b1;
        @(posedge CLK); #1;

        // ADD with carry-in, 1-cycle latency
        send(4'd0, 8'hFF, 8'h01, 1'b1, w);
        chk("add.waits",     w,         0);
        chk("add.out_valid", out_valid, 1'b1);
        chk("add.Result",    Result,    16'h0101);
        chk("add.C_out",     C_out,     1'b1);
        chk("add.Z_flag",    Z_flag,    1'b0);

        send(4'd1, 8'h05, 8'h05, 1'b0, w);
        chk("sub.Result", Result, 16'h0000);
        chk("sub.Z_flag", Z_flag, 1'b1);
        chk("sub.C_out",  C_out,  1'b0);

        send(4'd2, 8'hFF, 8'hFF, 1'b0, w);
        chk("mul.Result", Result, 16'hFE01);

        // DIV 200/7: WIDTH+1 cycle latency, busy meanwhile
        send(4'd3, 8'd200, 8'd7, 1'b0, w);
        lat = 1;
        busy_bad = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) busy_bad = 1'b1;
            @(posedge CLK); #1;
            lat++;
        end
        chk("div.latency",     lat,      9);
        chk("div.busy_ready",  busy_bad, 1'b0);
        chk("div.Result",      Result,   16'h041C);

        // Divide by zero, then illegal op
        send(4'd3, 8'h33, 8'h00, 1'b0, w);
        chk("div0.waits",  w,      0);
        chk("div0.Result", Result, 16'h33FF);
        chk("div0.Err",    Err,    1'b1);
        chk("div0.Z_flag", Z_flag, 1'b0);
        send(4'd9, 8'h12, 8'h34, 1'b1, w);
        chk("ill.Result", Result, 16'h0000);
        chk("ill.Z_flag", Z_flag, 1'b1);
        chk("ill.Err",    Err,    1'b1);
        chk("ill.C_out",  C_out,  1'b0);

        // Backpressure: result held for 5 cycles, nothing accepted
        @(posedge CLK); #1;
        out_ready = 1'b0;
        send(4'd0, 8'h10, 8'h20, 1'b0, w);
        repeat (5) begin
            @(negedge CLK);
            chk("hold.in_ready",  in_ready,  1'b0);
            chk("hold.out_valid", out_valid, 1'b1);
            chk("hold.Result",    Result,    16'h0030);
        end
        @(posedge CLK); #1;
        out_ready = 1'b1;

        // Back-to-back directed table with out_ready high
        foreach (tbl[i]) begin
            send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin, w);
            chk("tbl.waits", w, 0);
            lat = 0;
            while (!out_valid && lat < 40) begin
                @(posedge CLK); #1;
                lat++;
            end
            chk("tbl.Result", Result, {16'h0000, tbl[i].r});
        end

        // Same table under random backpressure; the compare process checks it
        bp_en = 1'b1;
        foreach (tbl[i]) send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin, w);
        bp_en = 1'b0;
        @(posedge CLK); #2;
        out_ready = 1'b1;
        lat = 0;
        while (q.size() != 0 && lat < 50) begin
            @(posedge CLK); #1;
            lat++;
        end
        chk("drain.outstanding", q.size(), 0);
        @(posedge CLK); #1;

        // Reset in the middle of a divide
        send(4'd3, 8'd250, 8'd3, 1'b0, w);
        repeat (3) @(posedge CLK);
        #1;
        Reset = 1'b1;
        @(posedge CLK); #1;
        chk("rstdiv.out_valid", out_valid, 1'b0);
        chk("rstdiv.in_ready",  in_ready,  1'b0);
        Reset = 1'b0;
        q.delete();
        send(4'd0, 8'h03, 8'h04, 1'b0, w);
        chk("rstdiv.next_waits", w,      0);
        chk("rstdiv.next_Result", Result, 16'h0007);
        @(posedge CLK); #1;
        @(posedge CLK); #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
